serial_shift_mc: RTL and testbench

Parametrised multi-channel serial shift-out engine, the next generation of the single-line SDO serialiser driven from the top level. It accepts one parallel word per channel through a valid/ready handshake and shifts all channels out in lockstep. Each word goes out on its own SDO line with a shared bit clock (SCK) and frame strobe. The engine adds a programmable bit rate, LSB/MSB ordering, an inter-word gap and an auto-repeat mode, and sits between the register/control logic and the device pins.

---
 rtl/serial_shift_mc.sv | 207 ++++++++++++++++++++
 tb/tb_serial_shift_mc.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_shift_mc.sv
// Multi-channel serial shift-out engine: one word per channel shifted in lockstep
// with a shared bit clock, frame strobe, optional inter-word gap and auto-repeat.
`timescale 1ns/1ps
module serial_shift_mc #(
   parameter int WIDTH      = 16,
   parameter int CHANNELS   = 2,
   parameter int DIV        = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [CHANNELS*WIDTH-1:0] DATA_IN,
   input  logic                      LOAD_VALID,
   output logic                      LOAD_READY,
   input  logic                      LSB_FIRST,
   input  logic                      REPEAT,
   input  logic                      STOP,
   output logic [CHANNELS-1:0]       SDO,
   output logic                      SCK,
   output logic                      FRAME,
   output logic                      BUSY,
   output logic                      DONE
);

   localparam int BW = $clog2(WIDTH);
   localparam int PW = $clog2(DIV);
   localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
   localparam logic [PW-1:0] PH_HALF  = PW'(DIV / 2);
   localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   typedef logic [CHANNELS-1:0][WIDTH-1:0] words_t;

   state_t              state_r, state_s;
   logic [PW-1:0]       phase_r, phase_s;
   logic [BW-1:0]       bit_r, bit_s;
   logic [GW-1:0]       gap_r, gap_s;
   words_t              sh_r, sh_s;
   words_t              hold_r, hold_s;
   logic                lsb_r, lsb_s;
   logic                rep_r, rep_s;
   logic                pend_r, pend_s;
   logic                init_r;
   logic                ready_s, load_s;
   logic [CHANNELS-1:0] sdo_r, sdo_s;
   logic                sck_r, sck_s;
   logic                frame_r, frame_s;
   logic                busy_r, busy_s;
   logic                done_r, done_s;

   // In GAP a new load is only offered while the word is set to repeat.
   assign ready_s = init_r & ((state_r == IDLE) | ((state_r == GAP) & rep_r));
   assign load_s  = LOAD_VALID & ready_s;

   // Next-state, counters, shift data and next output values.
   always_comb begin
      state_s = state_r;
      phase_s = phase_r;
      bit_s   = bit_r;
      gap_s   = gap_r;
      sh_s    = sh_r;
      hold_s  = hold_r;
      lsb_s   = lsb_r;
      pend_s  = pend_r;
      done_s  = 1'b0;

      if (load_s) begin
         rep_s  = REPEAT;
         hold_s = DATA_IN;
         lsb_s  = LSB_FIRST;
      end else if (STOP) begin
         rep_s = 1'b0;
      end else begin
         rep_s = rep_r;
      end

      case (state_r)
         IDLE: begin
            if (load_s) begin
               state_s = SHIFT;
               phase_s = '0;
               bit_s   = '0;
               sh_s    = DATA_IN;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            if (phase_r == PH_LAST) begin
               phase_s = '0;
               if (bit_r == BIT_LAST) begin
                  bit_s  = '0;
                  done_s = 1'b1;
                  if (GAP_CYCLES > 0) begin
                     state_s = GAP;
                     gap_s   = '0;
                  end else if (rep_s) begin
                     state_s = SHIFT;
                     sh_s    = hold_r;
                  end else begin
                     state_s = IDLE;
                  end
               end else begin
                  bit_s = bit_r + BW'(1);
                  for (int c = 0; c < CHANNELS; c++) begin
                     if (lsb_r) begin
                        sh_s[c] = {1'b0, sh_r[c][WIDTH-1:1]};
                     end else begin
                        sh_s[c] = {sh_r[c][WIDTH-2:0], 1'b0};
                     end
                  end
               end
            end else begin
               phase_s = phase_r + PW'(1);
            end
         end
         GAP: begin
            if (load_s) begin
               pend_s = 1'b1;
            end else begin
               pend_s = pend_r;
            end
            // The gap always runs its full length, even with a fresh load pending.
            if (gap_r == GAP_LAST) begin
               if (rep_s | pend_s) begin
                  state_s = SHIFT;
                  phase_s = '0;
                  bit_s   = '0;
                  sh_s    = hold_s;
                  pend_s  = 1'b0;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               gap_s = gap_r + GW'(1);
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      frame_s = (state_s == SHIFT);
      busy_s  = (state_s != IDLE);
      sck_s   = frame_s & (phase_s >= PH_HALF);
      for (int c = 0; c < CHANNELS; c++) begin
         if (lsb_s) begin
            sdo_s[c] = frame_s & sh_s[c][0];
         end else begin
            sdo_s[c] = frame_s & sh_s[c][WIDTH-1];
         end
      end
   end

   // State, data and output registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r <= IDLE;
         phase_r <= '0;
         bit_r   <= '0;
         gap_r   <= '0;
         sh_r    <= '0;
         hold_r  <= '0;
         lsb_r   <= 1'b0;
         rep_r   <= 1'b0;
         pend_r  <= 1'b0;
         init_r  <= 1'b0;
         sdo_r   <= '0;
         sck_r   <= 1'b0;
         frame_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         phase_r <= phase_s;
         bit_r   <= bit_s;
         gap_r   <= gap_s;
         sh_r    <= sh_s;
         hold_r  <= hold_s;
         lsb_r   <= lsb_s;
         rep_r   <= rep_s;
         pend_r  <= pend_s;
         init_r  <= 1'b1;
         sdo_r   <= sdo_s;
         sck_r   <= sck_s;
         frame_r <= frame_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   assign LOAD_READY = ready_s;
   assign SDO        = sdo_r;
   assign SCK        = sck_r;
   assign FRAME      = frame_r;
   assign BUSY       = busy_r;
   assign DONE       = done_r;

endmodule

// File: tb/tb_serial_shift_mc.sv
// Directed bench for serial_shift_mc: vector table for single words, plus
// repeat/STOP, load-during-gap, zero-gap repeat and mid-word reset sequences.
`timescale 1ns/1ps
module tb_serial_shift_mc;

   logic        clk;
   logic        rst;
   logic [15:0] din;
   logic        lv, lv0;
   logic        lsb, rep, stop;
   logic [1:0]  sdo, sdo0;
   logic        rdy, sck, frame, busy, done;
   logic        rdy0, sck0, frame0, busy0, done0;
   logic [6:0]  outv, outv0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] d0;
      logic [7:0] d1;
      logic       lsb;
      logic       stp;
      logic [7:0] e0;
      logic [7:0] e1;
   } vec_t;
   vec_t tbl [6];

   serial_shift_mc #(.WIDTH(8), .CHANNELS(2), .DIV(4), .GAP_CYCLES(2)) dut (
      .CLK(clk), .RST(rst), .DATA_IN(din), .LOAD_VALID(lv), .LOAD_READY(rdy),
      .LSB_FIRST(lsb), .REPEAT(rep), .STOP(stop), .SDO(sdo), .SCK(sck),
      .FRAME(frame), .BUSY(busy), .DONE(done));

   serial_shift_mc #(.WIDTH(8), .CHANNELS(2), .DIV(4), .GAP_CYCLES(0)) dut0 (
      .CLK(clk), .RST(rst), .DATA_IN(din), .LOAD_VALID(lv0), .LOAD_READY(rdy0),
      .LSB_FIRST(lsb), .REPEAT(rep), .STOP(stop), .SDO(sdo0), .SCK(sck0),
      .FRAME(frame0), .BUSY(busy0), .DONE(done0));

   assign outv  = {rdy, busy, frame, done, sck, sdo};
   assign outv0 = {rdy0, busy0, frame0, done0, sck0, sdo0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   // Expected {ready,busy,frame,done,sck,sdo1,sdo0} at cycle sn after a load, GAP=2.
   // e0/e1 bit i is the SDO value during bit period i.
   function automatic logic [6:0] exp_out(int sn, logic [7:0] e0, logic [7:0] e1, logic gap_rdy);
      if (sn < 32)
         return {1'b0, 1'b1, 1'b1, 1'b0, ((sn % 4) >= 2), e1[sn / 4], e0[sn / 4]};
      else if (sn == 32)
         return {gap_rdy, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00};
      else if (sn == 33)
         return {gap_rdy, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
      else
         return 7'b1000000;
   endfunction

   task automatic chk(input string nm, input int s, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got rdy/busy/frame/done/sck/sdo=%b want %b", nm, s, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for ready, then presents one load for exactly one edge.
   task automatic do_load(input logic [15:0] d, input logic l, input logic r,
                          input logic st, input bit use0);
      int n = 0;
      while (!(use0 ? rdy0 : rdy) && n < 50) begin
         step();
         n++;
      end
      checks++;
      if (!(use0 ? rdy0 : rdy)) begin
         errors++;
         $display("FAIL load_ready_wait got ready=0 after %0d cycles want 1", n);
      end
      din  = d;
      lsb  = l;
      rep  = r;
      stop = st;
      if (use0) lv0 = 1'b1;
      else      lv  = 1'b1;
      step();
      lv   = 1'b0;
      lv0  = 1'b0;
      rep  = 1'b0;
      stop = 1'b0;
   endtask

   initial begin
      tbl[0] = '{8'hA5, 8'h3C, 1'b0, 1'b0, 8'hA5, 8'h3C};
      tbl[1] = '{8'hA5, 8'h3C, 1'b1, 1'b0, 8'hA5, 8'h3C};
      tbl[2] = '{8'h01, 8'h80, 1'b1, 1'b1, 8'h01, 8'h80};
      tbl[3] = '{8'h01, 8'h80, 1'b0, 1'b0, 8'h80, 8'h01};
      tbl[4] = '{8'h12, 8'hC8, 1'b0, 1'b0, 8'h48, 8'h13};
      tbl[5] = '{8'h12, 8'hC8, 1'b1, 1'b0, 8'h12, 8'hC8};

      rst = 1'b1; din = 16'h0000; lv = 1'b0; lv0 = 1'b0;
      lsb = 1'b0; rep = 1'b0; stop = 1'b0;
      #3;
      chk("reset_state", 0, outv, 7'b0000000);
      step();
      rst = 1'b0;
      #1;
      chk("ready_before_edge", 0, outv, 7'b0000000);
      step();
      chk("ready_after_release", 0, outv, 7'b1000000);
      chk("ready_after_release_g0", 0, outv0, 7'b1000000);

      // Single words from the vector table.
      for (int v = 0; v < 6; v++) begin
         do_load({tbl[v].d1, tbl[v].d0}, tbl[v].lsb, 1'b0, tbl[v].stp, 1'b0);
         for (int s = 0; s <= 34; s++) begin
            chk($sformatf("vec%0d", v), s, outv, exp_out(s, tbl[v].e0, tbl[v].e1, 1'b0));
            if (s < 34) step();
         end
      end

      // Repeat 0x81 with STOP during the third word: three full words, then IDLE.
      do_load({8'h00, 8'h81}, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int s = 0; s <= 103; s++) begin
         int w, sn;
         w  = s / 34;
         sn = (s >= 102) ? 34 : (s % 34);
         chk("repeat_stop", s, outv, exp_out(sn, 8'h81, 8'h00, (w < 2)));
         if (s == 80) stop = 1'b1;
         if (s == 81) stop = 1'b0;
         if (s < 103) step();
      end

      // Load 0x5A/REPEAT=0 in the first gap cycle of a repeating word.
      do_load({8'h00, 8'h81}, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int s = 0; s <= 32; s++) begin
         chk("gapload_first", s, outv, exp_out(s, 8'h81, 8'h00, 1'b1));
         if (s < 32) step();
      end
      din = {8'h0F, 8'h5A}; lsb = 1'b0; rep = 1'b0; lv = 1'b1;
      step();
      lv = 1'b0;
      chk("gapload_gap2", 33, outv, exp_out(33, 8'h00, 8'h00, 1'b0));
      step();
      for (int s = 34; s <= 68; s++) begin
         chk("gapload_second", s, outv, exp_out(s - 34, 8'h5A, 8'hF0, 1'b0));
         if (s < 68) step();
      end

      // Zero-gap repeat: FRAME never drops, DONE every 32 cycles, STOP in word 3.
      do_load({8'h01, 8'h81}, 1'b0, 1'b1, 1'b0, 1'b1);
      for (int s = 0; s <= 97; s++) begin
         logic [6:0] e;
         logic [7:0] e0, e1;
         int sn;
         e0 = 8'h81; e1 = 8'h80; sn = s % 32;
         if (s < 96)
            e = {1'b0, 1'b1, 1'b1, (s > 0 && sn == 0), ((s % 4) >= 2), e1[sn / 4], e0[sn / 4]};
         else if (s == 96)
            e = 7'b1001000;
         else
            e = 7'b1000000;
         chk("gap0_repeat", s, outv0, e);
         if (s == 70) stop = 1'b1;
         if (s == 71) stop = 1'b0;
         if (s < 97) step();
      end

      // Reset in bit 3 of a word, then a clean word.
      do_load({8'h3C, 8'hA5}, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int s = 0; s <= 13; s++) begin
         chk("pre_reset", s, outv, exp_out(s, 8'hA5, 8'h3C, 1'b0));
         if (s < 13) step();
      end
      rst = 1'b1;
      #1;
      chk("reset_async", 13, outv, 7'b0000000);
      step();
      chk("reset_held", 14, outv, 7'b0000000);
      rst = 1'b0;
      #1;
      chk("reset_release", 14, outv, 7'b0000000);
      step();
      chk("reset_ready", 15, outv, 7'b1000000);
      do_load({8'hC8, 8'h12}, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int s = 0; s <= 34; s++) begin
         chk("post_reset", s, outv, exp_out(s, 8'h48, 8'h13, 1'b0));
         if (s < 34) step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
